// File: rtl/scan_ckpt_pkg.sv
// Shared types and helpers for the scan checkpoint sequencer.
// Holds the sequencer state encoding, transfer direction codes and counter sizing.
package scan_ckpt_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_PAUSE,
      ST_SCAN_ON,
      ST_RAM_RST,
      ST_FF,
      ST_RAM_PRE,
      ST_RAM,
      ST_RAM_POST,
      ST_SCAN_OFF,
      ST_RESUME
   } state_e;

   localparam logic DIR_DUMP = 1'b0;
   localparam logic DIR_LOAD = 1'b1;

   function automatic int clog2(input int value);
      int w;
      w = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) w = i + 1;
      end
      return w;
   endfunction

   // A counter must hold 0..max_count and is never narrower than one bit.
   function automatic int cnt_width(input int max_count);
      int w;
      w = clog2(max_count + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/scan_ckpt_ctrl_word_counter.sv
// Count-to-limit counter with a terminal flag; wraps to zero on the terminal increment.
// One instance per chain; the RAM instance is also reused for the prefetch/flush cycles.
module scan_word_counter #(
   parameter int WIDTH = 7
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic [WIDTH-1:0] limit,
   output logic             last
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   assign last = (count_q == (limit - WIDTH'(1)));

   always_comb begin
      count_d = count_q;
      if (inc) begin
         count_d = last ? '0 : count_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/scan_ckpt_ctrl.sv
// Host-side sequencer that pauses the target, walks the FF and RAM scan chains and
// turns them into valid/ready word streams for a checkpoint dump or restore.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// IDLE        | target running, waiting for a command
// PAUSE       | target clock stopped
// SCAN_ON     | scan mode selected
// RAM_RST     | one-cycle RAM scan pointer reset
// FF          | FF chain words streamed (out for dump, in for restore)
// RAM_PRE     | dump only: RAM read pipeline prefetch
// RAM         | RAM chain words streamed
// RAM_POST    | restore only: flush cycles replaying the last word
// SCAN_OFF    | scan mode released
// RESUME      | target clock restarted, done pulse
module scan_ckpt_ctrl
   import scan_ckpt_pkg::*;
#(
   parameter int DATA_WIDTH  = 64,
   parameter int FF_WORDS    = 16,
   parameter int MEM_WORDS   = 64,
   parameter int PRE_CYCLES  = 2,
   parameter int POST_CYCLES = 1
) (
   input  logic                  host_clk,
   input  logic                  host_rst_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_dir,
   output logic                  done,
   output logic                  busy,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  run_mode,
   output logic                  scan_mode,
   output logic                  ff_se,
   output logic [DATA_WIDTH-1:0] ff_di,
   input  logic [DATA_WIDTH-1:0] ff_do,
   output logic                  ram_sr,
   output logic                  ram_se,
   output logic                  ram_sd,
   output logic [DATA_WIDTH-1:0] ram_di,
   input  logic [DATA_WIDTH-1:0] ram_do
);

   localparam int MAX_WORDS = (FF_WORDS > MEM_WORDS) ? FF_WORDS : MEM_WORDS;
   localparam int MAX_EXTRA = (PRE_CYCLES > POST_CYCLES) ? PRE_CYCLES : POST_CYCLES;
   localparam int MAX_COUNT = (MAX_WORDS > MAX_EXTRA) ? MAX_WORDS : MAX_EXTRA;
   localparam int CW        = cnt_width(MAX_COUNT);

   localparam logic [CW-1:0] FF_LIMIT   = CW'(FF_WORDS);
   localparam logic [CW-1:0] MEM_LIMIT  = CW'(MEM_WORDS);
   localparam logic [CW-1:0] PRE_LIMIT  = CW'(PRE_CYCLES);
   localparam logic [CW-1:0] POST_LIMIT = CW'(POST_CYCLES);

   localparam bit HAS_FF   = (FF_WORDS > 0);
   localparam bit HAS_MEM  = (MEM_WORDS > 0);
   localparam bit HAS_PRE  = (PRE_CYCLES > 0);
   localparam bit HAS_POST = (POST_CYCLES > 0);

   state_e                state_q, state_d;
   state_e                after_ff;
   logic                  dir_q, dir_d;
   logic [DATA_WIDTH-1:0] ram_di_q, ram_di_d;
   logic                  xfer;
   logic                  ff_inc, ff_last;
   logic                  ram_inc, ram_last;
   logic [CW-1:0]         ram_limit;

   scan_word_counter #(.WIDTH(CW)) u_ff_cnt (
      .clk   (host_clk),
      .rst_n (host_rst_n),
      .inc   (ff_inc),
      .limit (FF_LIMIT),
      .last  (ff_last)
   );

   scan_word_counter #(.WIDTH(CW)) u_ram_cnt (
      .clk   (host_clk),
      .rst_n (host_rst_n),
      .inc   (ram_inc),
      .limit (ram_limit),
      .last  (ram_last)
   );

   always_comb begin
      state_d   = state_q;
      dir_d     = dir_q;
      ram_di_d  = ram_di_q;
      cmd_ready = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      run_mode  = 1'b0;
      scan_mode = 1'b0;
      ram_sr    = 1'b0;
      ff_se     = 1'b0;
      ram_se    = 1'b0;
      ram_sd    = 1'b0;
      ff_di     = '0;
      ram_di    = '0;
      out_valid = 1'b0;
      out_data  = '0;
      in_ready  = 1'b0;
      ff_inc    = 1'b0;
      ram_inc   = 1'b0;
      ram_limit = MEM_LIMIT;
      xfer      = (dir_q == DIR_DUMP) ? out_ready : in_valid;

      after_ff = ST_SCAN_OFF;
      if (HAS_MEM) begin
         after_ff = ((dir_q == DIR_DUMP) && HAS_PRE) ? ST_RAM_PRE : ST_RAM;
      end

      case (state_q)
         ST_IDLE: begin
            busy      = 1'b0;
            run_mode  = 1'b1;
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               dir_d   = cmd_dir;
               state_d = ST_PAUSE;
            end
         end
         ST_PAUSE: begin
            state_d = ST_SCAN_ON;
         end
         ST_SCAN_ON: begin
            scan_mode = 1'b1;
            state_d   = ST_RAM_RST;
         end
         ST_RAM_RST: begin
            scan_mode = 1'b1;
            ram_sr    = 1'b1;
            state_d   = HAS_FF ? ST_FF : after_ff;
         end
         ST_FF: begin
            scan_mode = 1'b1;
            if (dir_q == DIR_DUMP) begin
               // Dump recirculates the chain so the target state survives the read.
               out_valid = 1'b1;
               out_data  = ff_do;
               ff_se     = out_ready;
               ff_di     = ff_do;
            end else begin
               in_ready = 1'b1;
               ff_se    = in_valid;
               ff_di    = in_data;
            end
            ff_inc = xfer;
            if (xfer && ff_last) state_d = after_ff;
         end
         ST_RAM_PRE: begin
            scan_mode = 1'b1;
            ram_se    = 1'b1;
            ram_limit = PRE_LIMIT;
            ram_inc   = 1'b1;
            if (ram_last) state_d = ST_RAM;
         end
         ST_RAM: begin
            scan_mode = 1'b1;
            if (dir_q == DIR_DUMP) begin
               out_valid = 1'b1;
               out_data  = ram_do;
               ram_se    = out_ready;
            end else begin
               in_ready = 1'b1;
               ram_se   = in_valid;
               ram_sd   = 1'b1;
               ram_di   = in_data;
               if (in_valid) ram_di_d = in_data;
            end
            ram_inc = xfer;
            if (xfer && ram_last) begin
               state_d = ((dir_q == DIR_LOAD) && HAS_POST) ? ST_RAM_POST : ST_SCAN_OFF;
            end
         end
         ST_RAM_POST: begin
            scan_mode = 1'b1;
            ram_se    = 1'b1;
            ram_sd    = 1'b1;
            ram_di    = ram_di_q;
            ram_limit = POST_LIMIT;
            ram_inc   = 1'b1;
            if (ram_last) state_d = ST_SCAN_OFF;
         end
         ST_SCAN_OFF: begin
            state_d = ST_RESUME;
         end
         ST_RESUME: begin
            run_mode = 1'b1;
            done     = 1'b1;
            state_d  = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge host_clk or negedge host_rst_n) begin
      if (!host_rst_n) begin
         state_q  <= ST_IDLE;
         dir_q    <= DIR_DUMP;
         ram_di_q <= '0;
      end else begin
         state_q  <= state_d;
         dir_q    <= dir_d;
         ram_di_q <= ram_di_d;
      end
   end

endmodule
